// File: rtl/player_pkg.sv
// ----------------------------------------------------------------------------
// player_pkg
// Shared types and constants for the player vertical-motion logic.
//   phase_t                : vertical motion phase encoding (also the 2-bit
//                            phase output of player_jump_ctrl)
//   EDGE_*                 : bit positions inside the 4-bit HitEdgeCode bus
//   FIXED_POINT_MULTIPLIER : sub-pixel scale of speed / position values
// ----------------------------------------------------------------------------
package player_pkg;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        ASCEND   = 2'd1,
        HOVER    = 2'd2,
        FALL     = 2'd3
    } phase_t;

    localparam int EDGE_BOTTOM = 0;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_LEFT   = 3;

    localparam int FIXED_POINT_MULTIPLIER = 64;

endpackage

// File: rtl/frame_sticky_flag.sv
// ----------------------------------------------------------------------------
// frame_sticky_flag
// Remembers that an event happened at some point during the current frame.
//   clk         : system clock
//   resetN      : asynchronous active-low reset
//   hit         : event strobe, any cycle
//   frame_pulse : start-of-frame pulse; the flag is consumed and restarted
//   clear       : synchronous clear, highest priority
//   flag        : registered sticky flag
// An event coinciding with frame_pulse restarts the flag already set, so it
// is credited to the frame that is just beginning.
// ----------------------------------------------------------------------------
module frame_sticky_flag (
    input  logic clk,
    input  logic resetN,
    input  logic hit,
    input  logic frame_pulse,
    input  logic clear,
    output logic flag
);

    logic flag_reg;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flag_reg <= 1'b0;
        end else if (clear) begin
            flag_reg <= 1'b0;
        end else if (frame_pulse) begin
            flag_reg <= hit;
        end else if (hit) begin
            flag_reg <= 1'b1;
        end
    end

    assign flag = flag_reg;

endmodule

// File: rtl/player_jump_ctrl.sv
// ----------------------------------------------------------------------------
// player_jump_ctrl
// Per-frame vertical-motion sequencer for the player sprite. Walks through
// GROUNDED / ASCEND / HOVER / FALL, limits jump height, requires the jump key
// to be released before another jump, and applies saturating gravity.
//   clk          : system clock
//   resetN       : asynchronous active-low reset
//   startOfFrame : one-cycle pulse per frame; all phase decisions happen here
//   jump_key     : active-low jump key (level)
//   collision    : player/object collision, any cycle
//   HitEdgeCode  : [0] player bottom (floor), [2] player top (ceiling)
//   respawn      : one-cycle pulse, returns to FALL with zero speed
//   freeze       : hold all state, Yspeed forced to 0
//   Yspeed       : registered signed Y speed (1/64 px per frame)
//   phase        : current phase (player_pkg::phase_t encoding)
//   jumping      : high in ASCEND or HOVER
// ----------------------------------------------------------------------------
module player_jump_ctrl
    import player_pkg::*;
#(
    parameter int SPEED_W      = 8,
    parameter int JUMP_SPEED   = -30,
    parameter int JUMP_FRAMES  = 16,
    parameter int HOVER_FRAMES = 4,
    parameter int GRAV_ACCEL   = 2,
    parameter int MAX_FALL     = 40
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      jump_key,
    input  logic                      collision,
    input  logic [3:0]                HitEdgeCode,
    input  logic                      respawn,
    input  logic                      freeze,
    output logic signed [SPEED_W-1:0] Yspeed,
    output logic [1:0]                phase,
    output logic                      jumping
);

    localparam int CNT_RANGE = (JUMP_FRAMES > HOVER_FRAMES)
                             ? ((JUMP_FRAMES > 2) ? JUMP_FRAMES : 2)
                             : ((HOVER_FRAMES > 2) ? HOVER_FRAMES : 2);
    localparam int CNT_W = $clog2(CNT_RANGE);

    localparam logic [CNT_W-1:0] JUMP_LOAD  = CNT_W'(JUMP_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOVER_LOAD = CNT_W'((HOVER_FRAMES > 0) ? HOVER_FRAMES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic signed [SPEED_W-1:0] JUMP_V = SPEED_W'(JUMP_SPEED);
    localparam logic signed [SPEED_W-1:0] GRAV_V = SPEED_W'(GRAV_ACCEL);
    localparam logic signed [SPEED_W-1:0] MAX_V  = SPEED_W'(MAX_FALL);
    localparam logic signed [SPEED_W:0]   GRAV_W = (SPEED_W + 1)'(GRAV_ACCEL);
    localparam logic signed [SPEED_W:0]   MAX_W  = (SPEED_W + 1)'(MAX_FALL);

    phase_t                      phase_reg, phase_next;
    logic [CNT_W-1:0]            cnt_reg, cnt_next;
    logic signed [SPEED_W-1:0]   yspeed_reg, yspeed_next;
    logic                        armed_reg, armed_next;

    logic ground_seen, ceil_seen;
    logic flag_clear;
    logic signed [SPEED_W:0] fall_sum;

    // Side edges carry no vertical meaning here.
    logic unused_edges;
    assign unused_edges = HitEdgeCode[EDGE_RIGHT] ^ HitEdgeCode[EDGE_LEFT];

    assign flag_clear = respawn | freeze;

    frame_sticky_flag u_ground_flag (
        .clk         (clk),
        .resetN      (resetN),
        .hit         (collision & HitEdgeCode[EDGE_BOTTOM]),
        .frame_pulse (startOfFrame),
        .clear       (flag_clear),
        .flag        (ground_seen)
    );

    frame_sticky_flag u_ceil_flag (
        .clk         (clk),
        .resetN      (resetN),
        .hit         (collision & HitEdgeCode[EDGE_TOP]),
        .frame_pulse (startOfFrame),
        .clear       (flag_clear),
        .flag        (ceil_seen)
    );

    // One extra bit so the gravity add can never wrap before saturation.
    assign fall_sum = {yspeed_reg[SPEED_W-1], yspeed_reg} + GRAV_W;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            phase_reg  <= FALL;
            cnt_reg    <= '0;
            yspeed_reg <= '0;
            armed_reg  <= 1'b0;
        end else begin
            phase_reg  <= phase_next;
            cnt_reg    <= cnt_next;
            yspeed_reg <= yspeed_next;
            armed_reg  <= armed_next;
        end
    end

    always_comb begin
        phase_next  = phase_reg;
        cnt_next    = cnt_reg;
        yspeed_next = yspeed_reg;
        armed_next  = armed_reg;

        if (respawn) begin
            phase_next  = FALL;
            cnt_next    = '0;
            yspeed_next = '0;
            armed_next  = 1'b0;
        end else if (freeze) begin
            // Zeroing the speed register also makes a frozen fall restart
            // from GRAV_ACCEL once released.
            yspeed_next = '0;
        end else if (startOfFrame) begin
            // Releasing the key (high) arms the next jump.
            if (jump_key) begin
                armed_next = 1'b1;
            end
            unique case (phase_reg)
                GROUNDED: begin
                    if (!ground_seen) begin
                        phase_next  = FALL;
                        yspeed_next = GRAV_V;
                    end else if (armed_reg && !jump_key) begin
                        phase_next  = ASCEND;
                        cnt_next    = JUMP_LOAD;
                        yspeed_next = JUMP_V;
                        armed_next  = 1'b0;
                    end else begin
                        yspeed_next = '0;
                    end
                end
                ASCEND: begin
                    // Floor contact is ignored here: the feet are still
                    // touching the platform right after launch.
                    if (ceil_seen) begin
                        phase_next  = FALL;
                        yspeed_next = GRAV_V;
                    end else if (cnt_reg == '0) begin
                        if (HOVER_FRAMES == 0) begin
                            phase_next  = FALL;
                            yspeed_next = GRAV_V;
                        end else begin
                            phase_next  = HOVER;
                            cnt_next    = HOVER_LOAD;
                            yspeed_next = '0;
                        end
                    end else begin
                        cnt_next    = cnt_reg - CNT_ONE;
                        yspeed_next = JUMP_V;
                    end
                end
                HOVER: begin
                    if (ground_seen) begin
                        phase_next  = GROUNDED;
                        yspeed_next = '0;
                    end else if (cnt_reg == '0) begin
                        phase_next  = FALL;
                        yspeed_next = GRAV_V;
                    end else begin
                        cnt_next    = cnt_reg - CNT_ONE;
                        yspeed_next = '0;
                    end
                end
                FALL: begin
                    if (ground_seen) begin
                        phase_next  = GROUNDED;
                        yspeed_next = '0;
                    end else if (fall_sum > MAX_W) begin
                        yspeed_next = MAX_V;
                    end else begin
                        yspeed_next = fall_sum[SPEED_W-1:0];
                    end
                end
                default: begin
                    phase_next = FALL;
                end
            endcase
        end
    end

    assign Yspeed  = yspeed_reg;
    assign phase   = phase_reg;
    assign jumping = (phase_reg == ASCEND) || (phase_reg == HOVER);

endmodule

// File: tb/tb_player_jump_ctrl.sv
// ----------------------------------------------------------------------------
// tb_player_jump_ctrl
// Frame-based stimulus (4 cycles per frame, startOfFrame on the first) with a
// directed sequence followed by random frames. A plain-integer reference
// model counts elapsed ascent/hover frames and applies the phase rules once
// per frame; outputs are compared every cycle.
// ----------------------------------------------------------------------------
module tb_player_jump_ctrl;
    import player_pkg::*;

    localparam int SPEED_W      = 8;
    localparam int JUMP_SPEED   = -30;
    localparam int JUMP_FRAMES  = 16;
    localparam int HOVER_FRAMES = 4;
    localparam int GRAV_ACCEL   = 2;
    localparam int MAX_FALL     = 40;
    localparam int FRAME_LEN    = 4;

    localparam int P_GND  = 0;
    localparam int P_ASC  = 1;
    localparam int P_HOV  = 2;
    localparam int P_FALL = 3;

    logic                      clk = 1'b0;
    logic                      resetN;
    logic                      startOfFrame;
    logic                      jump_key;
    logic                      collision;
    logic [3:0]                HitEdgeCode;
    logic                      respawn;
    logic                      freeze;
    logic signed [SPEED_W-1:0] Yspeed;
    logic [1:0]                phase;
    logic                      jumping;

    always #5 clk = ~clk;

    player_jump_ctrl #(
        .SPEED_W      (SPEED_W),
        .JUMP_SPEED   (JUMP_SPEED),
        .JUMP_FRAMES  (JUMP_FRAMES),
        .HOVER_FRAMES (HOVER_FRAMES),
        .GRAV_ACCEL   (GRAV_ACCEL),
        .MAX_FALL     (MAX_FALL)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .jump_key     (jump_key),
        .collision    (collision),
        .HitEdgeCode  (HitEdgeCode),
        .respawn      (respawn),
        .freeze       (freeze),
        .Yspeed       (Yspeed),
        .phase        (phase),
        .jumping      (jumping)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int frame_no = 0;

    // Reference model state
    int m_phase;
    int m_speed;
    int m_done;     // frames already spent in the current ascent / hover
    bit m_gnd;
    bit m_ceil;
    bit m_armed;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (frame %0d, t=%0t)",
                     tag, obs, exp, frame_no, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_FALL;
        m_speed = 0;
        m_done  = 0;
        m_gnd   = 1'b0;
        m_ceil  = 1'b0;
        m_armed = 1'b0;
    endtask

    // Phase rules applied once per frame.
    task automatic model_frame(input bit gs, input bit cs, input bit key);
        bit launch;
        launch = 1'b0;
        case (m_phase)
            P_GND: begin
                if (!gs) begin
                    m_phase = P_FALL; m_speed = GRAV_ACCEL;
                end else if (m_armed && !key) begin
                    m_phase = P_ASC; m_done = 1; m_speed = JUMP_SPEED; launch = 1'b1;
                end else begin
                    m_speed = 0;
                end
            end
            P_ASC: begin
                if (cs) begin
                    m_phase = P_FALL; m_speed = GRAV_ACCEL;
                end else if (m_done >= JUMP_FRAMES) begin
                    if (HOVER_FRAMES > 0) begin
                        m_phase = P_HOV; m_done = 1; m_speed = 0;
                    end else begin
                        m_phase = P_FALL; m_speed = GRAV_ACCEL;
                    end
                end else begin
                    m_done++; m_speed = JUMP_SPEED;
                end
            end
            P_HOV: begin
                if (gs) begin
                    m_phase = P_GND; m_speed = 0;
                end else if (m_done >= HOVER_FRAMES) begin
                    m_phase = P_FALL; m_speed = GRAV_ACCEL;
                end else begin
                    m_done++; m_speed = 0;
                end
            end
            default: begin
                if (gs) begin
                    m_phase = P_GND; m_speed = 0;
                end else begin
                    m_speed = (m_speed + GRAV_ACCEL > MAX_FALL) ? MAX_FALL : m_speed + GRAV_ACCEL;
                end
            end
        endcase
        if (launch) m_armed = 1'b0;
        else if (key) m_armed = 1'b1;
    endtask

    task automatic model_cycle(input bit sof, input bit key, input bit coll,
                               input bit [3:0] ec, input bit resp, input bit frz);
        bit ev_g, ev_c, gs, cs;
        ev_g = coll && ec[0];
        ev_c = coll && ec[2];
        if (resp) begin
            model_reset();
        end else if (frz) begin
            m_speed = 0;
            m_gnd   = 1'b0;
            m_ceil  = 1'b0;
        end else if (sof) begin
            gs = m_gnd;
            cs = m_ceil;
            m_gnd  = ev_g;
            m_ceil = ev_c;
            model_frame(gs, cs, key);
        end else begin
            m_gnd  = m_gnd  | ev_g;
            m_ceil = m_ceil | ev_c;
        end
    endtask

    task automatic do_cycle(input bit sof, input bit key, input bit [3:0] ec,
                            input bit resp, input bit frz);
        startOfFrame = sof;
        jump_key     = key;
        collision    = (ec != 4'd0);
        HitEdgeCode  = ec;
        respawn      = resp;
        freeze       = frz;
        @(posedge clk);
        model_cycle(sof, key, (ec != 4'd0), ec, resp, frz);
        #1;
        check_val("phase",   int'(phase),   m_phase);
        check_val("yspeed",  int'(Yspeed),  m_speed);
        check_val("jumping", int'(jumping), int'(m_phase == P_ASC || m_phase == P_HOV));
    endtask

    // key: jump_key level for the frame; ec: collision code at cycle coll_cyc;
    // sof_ec: collision code on the startOfFrame cycle; resp_cyc: 0 = none.
    task automatic run_frame(input bit key, input bit [3:0] ec, input int coll_cyc,
                             input bit [3:0] sof_ec, input bit frz, input int resp_cyc);
        bit [3:0] code;
        for (int c = 0; c < FRAME_LEN; c++) begin
            if (c == 0)             code = sof_ec;
            else if (c == coll_cyc) code = ec;
            else                    code = 4'd0;
            do_cycle((c == 0), key, code, (resp_cyc != 0 && resp_cyc == c), frz);
        end
        frame_no++;
        $display("frame %0d key=%0d ec=%0h frz=%0d resp=%0d -> phase=%0d yspeed=%0d jumping=%0d",
                 frame_no, key, ec, frz, resp_cyc != 0, phase, Yspeed, jumping);
    endtask

    task automatic plain(input bit key, input bit [3:0] ec);
        run_frame(key, ec, 2, 4'd0, 1'b0, 0);
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        jump_key     = 1'b0;
        collision    = 1'b0;
        HitEdgeCode  = 4'd0;
        respawn      = 1'b0;
        freeze       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_phase",   int'(phase),   P_FALL);
        check_val("rst_yspeed",  int'(Yspeed),  0);
        check_val("rst_jumping", int'(jumping), 0);
        resetN = 1'b1;

        // Free fall from reset with the key held: ramp then saturation.
        for (int k = 1; k <= 25; k++) begin
            plain(1'b0, 4'd0);
            check_val("fall_ramp", int'(Yspeed), (2 * k > MAX_FALL) ? MAX_FALL : 2 * k);
        end
        check_val("fall_sat", int'(Yspeed), 40);

        // Landing with key still held from reset: no jump.
        for (int k = 0; k < 5; k++) plain(1'b0, 4'b0001);
        check_val("no_autojump_ph", int'(phase), P_GND);
        check_val("no_autojump_sp", int'(Yspeed), 0);

        // Release one frame, then press: launch.
        plain(1'b1, 4'b0001);
        plain(1'b0, 4'b0001);
        check_val("launch_ph", int'(phase), P_ASC);
        check_val("launch_sp", int'(Yspeed), -30);
        check_val("launch_jmp", int'(jumping), 1);

        // Full jump: 15 more ascent frames, 4 hover frames, then fall.
        for (int k = 0; k < 15; k++) plain(1'b0, 4'd0);
        check_val("asc_last_sp", int'(Yspeed), -30);
        for (int k = 0; k < 4; k++) begin
            plain(1'b0, 4'd0);
            check_val("hover_ph", int'(phase), P_HOV);
            check_val("hover_sp", int'(Yspeed), 0);
        end
        plain(1'b0, 4'd0);
        check_val("apex_fall_ph", int'(phase), P_FALL);
        check_val("apex_fall_sp", int'(Yspeed), 2);
        check_val("apex_fall_jmp", int'(jumping), 0);

        // Land, re-arm, jump, head bump in ascent frame 5.
        plain(1'b0, 4'b0001);
        plain(1'b1, 4'b0001);
        plain(1'b0, 4'b0001);
        for (int k = 0; k < 3; k++) plain(1'b0, 4'd0);
        plain(1'b0, 4'b0100);
        plain(1'b0, 4'd0);
        check_val("ceil_abort_ph", int'(phase), P_FALL);
        check_val("ceil_abort_sp", int'(Yspeed), 2);

        // Floor and ceiling together while falling: floor wins.
        plain(1'b0, 4'b0101);
        plain(1'b0, 4'd0);
        check_val("gnd_ceil_ph", int'(phase), P_GND);
        check_val("gnd_ceil_sp", int'(Yspeed), 0);

        // Respawn, then a floor hit coinciding with startOfFrame.
        run_frame(1'b0, 4'd0, 2, 4'd0, 1'b0, 1);
        check_val("respawn_ph", int'(phase), P_FALL);
        check_val("respawn_sp", int'(Yspeed), 0);
        run_frame(1'b0, 4'd0, 2, 4'b0001, 1'b0, 0);
        check_val("sof_late_ph", int'(phase), P_FALL);
        check_val("sof_late_sp", int'(Yspeed), 2);
        plain(1'b0, 4'b0001);
        check_val("sof_next_ph", int'(phase), P_GND);

        // Freeze for 10 frames after ascent frame 5, then resume.
        plain(1'b1, 4'b0001);
        plain(1'b0, 4'b0001);
        for (int k = 0; k < 4; k++) plain(1'b0, 4'd0);
        for (int k = 0; k < 10; k++) run_frame(1'b0, 4'b0101, 2, 4'd0, 1'b1, 0);
        check_val("frz_hold_ph", int'(phase), P_ASC);
        check_val("frz_hold_sp", int'(Yspeed), 0);
        plain(1'b0, 4'd0);
        check_val("frz_resume_sp", int'(Yspeed), -30);
        for (int k = 0; k < 10; k++) plain(1'b0, 4'd0);
        check_val("frz_asc_end_ph", int'(phase), P_ASC);
        plain(1'b0, 4'd0);
        check_val("hover_reached", int'(phase), P_HOV);

        // Respawn while frozen in hover.
        run_frame(1'b0, 4'd0, 2, 4'd0, 1'b1, 2);
        check_val("resp_frz_ph", int'(phase), P_FALL);
        check_val("resp_frz_sp", int'(Yspeed), 0);
        check_val("resp_frz_jmp", int'(jumping), 0);
        for (int k = 0; k < 3; k++) plain(1'b0, 4'b0001);
        check_val("no_rearm_ph", int'(phase), P_GND);

        // Asynchronous reset in the middle of a jump.
        plain(1'b1, 4'b0001);
        plain(1'b0, 4'b0001);
        plain(1'b0, 4'd0);
        #2;
        resetN = 1'b0;
        #1;
        check_val("areset_ph", int'(phase), P_FALL);
        check_val("areset_sp", int'(Yspeed), 0);
        check_val("areset_jmp", int'(jumping), 0);
        startOfFrame = 1'b0;
        collision    = 1'b0;
        HitEdgeCode  = 4'd0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();

        // Random frames.
        for (int f = 0; f < 300; f++) begin
            bit       key, frz;
            bit [3:0] ec, sof_ec;
            int       r, resp_cyc;
            key = bit'($urandom_range(0, 1));
            r = $urandom_range(0, 7);
            case (r)
                4:       ec = 4'b0001;
                5:       ec = 4'b0100;
                6:       ec = 4'b0101;
                7:       ec = 4'($urandom_range(0, 15));
                default: ec = (f % 3 == 0) ? 4'b0001 : 4'd0;
            endcase
            sof_ec   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            frz      = ($urandom_range(0, 9) == 0);
            resp_cyc = ($urandom_range(0, 29) == 0) ? $urandom_range(1, 3) : 0;
            run_frame(key, ec, $urandom_range(1, 3), sof_ec, frz, resp_cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/player_jump_ctrl.md
Name: player_jump_ctrl

Overview:
- Per-frame vertical-motion sequencer for the player sprite.
- Tracks the grounded / ascending / hovering / falling phases, enforces a finite jump height and a release-before-rejump rule, and applies accelerated gravity with a terminal speed.
- Produces the signed Y-speed command that the player position integrator adds to its fixed-point Y position once per frame.
- Sits between the keyboard/collision logic and the player movement/position block.

Parameters:
- SPEED_W, 8, width of signed Yspeed output.
- JUMP_SPEED, -30, Yspeed during ascent, in 1/64 px per frame.
- JUMP_FRAMES, 16, number of frames in the ascent phase (min 1).
- HOVER_FRAMES, 4, number of zero-speed frames at the apex (0 skips hover).
- GRAV_ACCEL, 2, Yspeed increment per falling frame.
- MAX_FALL, 40, terminal fall speed (positive, ≤ 2^(SPEED_W-1)-1).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame; all phase decisions happen on it
- jump_key  in  1  active-low jump key, level
- collision  in  1  player-object collision, valid any cycle of the frame
- HitEdgeCode  in  4  [0]=player bottom (floor), [2]=player top (ceiling); [3],[1] ignored
- respawn  in  1  synchronous one-cycle pulse on level start or death
- freeze  in  1  level: hold all state and output Yspeed=0
- Yspeed  out  SPEED_W  signed Y speed command, registered
- phase  out  2  0=GROUNDED, 1=ASCEND, 2=HOVER, 3=FALL
- jumping  out  1  high in ASCEND or HOVER

Behaviour:
- Reset (async): phase=FALL, Yspeed=0, frame counter=0, groundSeen=ceilSeen=0, armed=0, jumping=0.
- Sticky flags:
  - groundSeen is set on any cycle with collision && HitEdgeCode[0].
  - ceilSeen is set on any cycle with collision && HitEdgeCode[2].
  - Both are consumed and cleared on startOfFrame.
  - A collision in the same cycle as startOfFrame counts toward the next frame.
- armed:
  - Set on startOfFrame when jump_key=1.
  - Cleared when a jump launches.
  - A key held through reset or landing never auto-jumps.
- All transitions and outputs update 1 cycle after startOfFrame (registered). Between frames, outputs are stable.
- GROUNDED:
  - !groundSeen -> FALL, Yspeed=GRAV_ACCEL.
  - else if armed && jump_key=0 -> ASCEND, cnt=JUMP_FRAMES-1, Yspeed=JUMP_SPEED, armed=0.
  - else stay, Yspeed=0.
- ASCEND:
  - ceilSeen -> FALL, Yspeed=GRAV_ACCEL (head bump aborts the jump).
  - else if cnt=0 -> HOVER with cnt=HOVER_FRAMES-1, Yspeed=0; if HOVER_FRAMES=0 -> FALL, Yspeed=GRAV_ACCEL.
  - else cnt-1, Yspeed=JUMP_SPEED.
  - groundSeen is ignored during ascent (side/feet contact at launch).
- HOVER:
  - groundSeen -> GROUNDED, Yspeed=0.
  - else if cnt=0 -> FALL, Yspeed=GRAV_ACCEL.
  - else cnt-1, Yspeed=0.
- FALL:
  - groundSeen -> GROUNDED, Yspeed=0.
  - else Yspeed = min(Yspeed+GRAV_ACCEL, MAX_FALL).
  - Compute the sum in SPEED_W+1 bits, then saturate; no wrap.
- Simultaneous ground and ceiling in the same frame: ground wins in GROUNDED/HOVER/FALL; ceiling wins in ASCEND.
- freeze=1:
  - startOfFrame is ignored and phase/cnt/armed are held.
  - Yspeed forced to 0 while frozen.
  - Sticky flags are held clear.
  - On release, the next startOfFrame evaluates normally with the stored state.
  - Yspeed in FALL restarts from GRAV_ACCEL.
- respawn (highest priority, any cycle, overrides freeze):
  - Next cycle: phase=FALL, Yspeed=0, cnt=0, flags=0, armed=0.
- Reset mid-jump returns to the reset state immediately (async).
- cnt width: clog2(max(JUMP_FRAMES,HOVER_FRAMES,2)).

Decomposition:
- Package player_pkg holds:
  - typedef enum logic[1:0] phase_t {GROUNDED, ASCEND, HOVER, FALL};
  - the HitEdgeCode bit-index constants EDGE_BOTTOM=0, EDGE_RIGHT=1, EDGE_TOP=2, EDGE_LEFT=3;
  - FIXED_POINT_MULTIPLIER=64.
- One sub-module, frame_sticky_flag: set-on-event, clear-on-frame-pulse, with a synchronous clear for respawn/freeze. It is instantiated twice (ground, ceiling).
- The FSM, counter and saturating adder stay in the top level.

Test Plan:
- Reset, no collisions, 25 frames -> phase=FALL; Yspeed 2,4,...,40, then held at 40 (saturation).
- Ground collision each frame, jump_key held low from reset -> stays GROUNDED, Yspeed=0 (not armed). Release 1 frame, press -> ASCEND, Yspeed=-30.
- Full jump with no ceiling -> 16 frames at -30, 4 frames at 0 (HOVER), then FALL with Yspeed=2, jumping=1 during ASCEND/HOVER only.
- Ceiling collision in ascent frame 5 -> next update phase=FALL, Yspeed=2.
- Ground and ceiling in the same frame while in FALL -> GROUNDED, Yspeed=0.
- Collision in the same cycle as startOfFrame -> not seen that frame, acted on next.
- freeze mid-ascent for 10 frames -> Yspeed=0, cnt held; after release the ascent resumes with the remaining frames.
- respawn during HOVER with freeze=1 -> FALL, Yspeed=0, armed=0.
